// File: rtl/prog_encoder.sv
// Streaming instruction encoder: turns one handshaked instruction into one or
// two program-memory byte writes, tracking the next free address in pc.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a new instruction (in_ready=1)
// EMIT_OP   | writing the opcode byte at pc
// EMIT_IMM  | writing the immediate / relative jump offset at pc
// HALT      | HLT written; frozen until reset
module prog_encoder #(
    parameter int MEMSIZE = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [1:0] in_x,
    input  logic [1:0] in_y,
    input  logic       in_use_imm,
    input  logic [7:0] in_imm,
    output logic       write_flag,
    output logic [7:0] write_addr,
    output logic [7:0] write_value,
    output logic [7:0] pc,
    output logic       err,
    output logic       halted
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EMIT_OP  = 2'd1;
    localparam logic [1:0] EMIT_IMM = 2'd2;
    localparam logic [1:0] HALT     = 2'd3;

    localparam logic [8:0] MEM_LIMIT = 9'(MEMSIZE);

    logic [1:0] state;
    logic [7:0] op_byte;
    logic [7:0] imm_byte;
    logic       two_byte;
    logic       is_hlt;

    logic [7:0] enc_op;
    logic [7:0] enc_imm;
    logic [1:0] enc_len;
    logic       enc_legal;
    logic       enc_hlt;
    logic       enc_room;
    logic       handshake;

    always_comb begin
        enc_op    = 8'h00;
        enc_imm   = in_imm;
        enc_len   = 2'd1;
        enc_legal = 1'b1;
        enc_hlt   = 1'b0;
        case (in_op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                enc_op  = {1'b0, in_use_imm, in_op[1:0], in_x, (in_use_imm ? 2'b00 : in_y)};
                enc_len = in_use_imm ? 2'd2 : 2'd1;
            end
            4'd4: enc_op = {4'b1000, in_x, 2'b00};
            4'd5: enc_op = {4'b1001, in_x, 2'b00};
            4'd6, 4'd7, 4'd8: begin
                // Jumps store an offset relative to the address after the 2-byte instruction.
                enc_op  = (in_op == 4'd6) ? 8'hC0 : (in_op == 4'd7) ? 8'hD0 : 8'hE0;
                enc_imm = in_imm - (pc + 8'd2);
                enc_len = 2'd2;
            end
            4'd9: begin
                enc_op  = 8'hF0;
                enc_hlt = 1'b1;
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign enc_room  = ({1'b0, pc} + {7'b0, enc_len}) <= MEM_LIMIT;
    assign in_ready  = (state == IDLE);
    assign handshake = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= 8'h00;
            err      <= 1'b0;
            halted   <= 1'b0;
            op_byte  <= 8'h00;
            imm_byte <= 8'h00;
            two_byte <= 1'b0;
            is_hlt   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (enc_legal && enc_room) begin
                            op_byte  <= enc_op;
                            imm_byte <= enc_imm;
                            two_byte <= (enc_len == 2'd2);
                            is_hlt   <= enc_hlt;
                            state    <= EMIT_OP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                EMIT_OP: begin
                    pc <= pc + 8'd1;
                    if (is_hlt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (two_byte) begin
                        state <= EMIT_IMM;
                    end else begin
                        state <= IDLE;
                    end
                end
                EMIT_IMM: begin
                    pc    <= pc + 8'd1;
                    state <= IDLE;
                end
                default: state <= HALT;
            endcase
        end
    end

    // A cycle with reset asserted never presents a write, so an aborted instruction leaves no trace.
    always_comb begin
        write_flag  = 1'b0;
        write_addr  = 8'h00;
        write_value = 8'h00;
        if (!rst && (state == EMIT_OP || state == EMIT_IMM)) begin
            write_flag  = 1'b1;
            write_addr  = pc;
            write_value = (state == EMIT_OP) ? op_byte : imm_byte;
        end
    end

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: directed scenarios plus random instruction stream
// checked against a byte-level model of the instruction encoding rules.
module tb_prog_encoder;

    localparam int MEMSIZE = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [1:0] in_x;
    logic [1:0] in_y;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic       write_flag;
    logic [7:0] write_addr;
    logic [7:0] write_value;
    logic [7:0] pc;
    logic       err;
    logic       halted;

    int n_checks = 0;
    int n_errs   = 0;
    int mpc      = 0;
    bit mhalt    = 0;

    always #5 clk = ~clk;

    prog_encoder #(.MEMSIZE(MEMSIZE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .write_flag(write_flag), .write_addr(write_addr),
        .write_value(write_value), .pc(pc), .err(err), .halted(halted)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Encoding rules expressed as byte arithmetic on the mnemonic fields.
    function automatic void model_encode(input int op, input int x, input int y, input int ui,
                                         input int imm, input int pcv,
                                         output int b0, output int b1, output int len,
                                         output bit legal);
        legal = 1;
        b0 = 0;
        b1 = 0;
        len = 1;
        if (op <= 3) begin
            b0  = ui * 64 + op * 16 + x * 4 + (ui != 0 ? 0 : y);
            len = (ui != 0) ? 2 : 1;
            b1  = imm;
        end else if (op == 4) begin
            b0 = 128 + x * 4;
        end else if (op == 5) begin
            b0 = 144 + x * 4;
        end else if (op <= 8) begin
            b0  = 192 + (op - 6) * 16;
            len = 2;
            b1  = (imm - pcv - 2 + 512) % 256;
        end else if (op == 9) begin
            b0 = 240;
        end else begin
            legal = 0;
            len   = 0;
        end
    endfunction

    task automatic scramble_inputs();
        in_op      = 4'($urandom);
        in_x       = 2'($urandom);
        in_y       = 2'($urandom);
        in_use_imm = 1'($urandom);
        in_imm     = 8'($urandom);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        mpc   = 0;
        mhalt = 0;
        check_val("rst_ready", in_ready, 1);
        check_val("rst_pc", pc, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_err", err, 0);
        check_val("rst_wflag", write_flag, 0);
        check_val("rst_waddr", write_addr, 0);
        check_val("rst_wval", write_value, 0);
    endtask

    task automatic issue(input int op, input int x, input int y, input int ui, input int imm);
        int b0, b1, len, waits;
        bit legal, ok;
        waits = 0;
        while (!in_ready && waits < 20) begin
            step();
            waits++;
        end
        check_val("ready_wait", in_ready, 1);
        model_encode(op, x, y, ui, imm, mpc, b0, b1, len, legal);
        ok = legal && (mpc + len <= MEMSIZE);
        in_valid   = 1'b1;
        in_op      = 4'(op);
        in_x       = 2'(x);
        in_y       = 2'(y);
        in_use_imm = 1'(ui);
        in_imm     = 8'(imm);
        step();
        in_valid = 1'b0;
        scramble_inputs();
        check_val("pc_at_n1", pc, mpc);
        if (!ok) begin
            check_val("err_pulse", err, 1);
            check_val("err_nowrite", write_flag, 0);
            step();
            check_val("err_clear", err, 0);
            check_val("err_pc", pc, mpc);
            check_val("err_ready", in_ready, 1);
        end else begin
            check_val("op_err", err, 0);
            check_val("op_wflag", write_flag, 1);
            check_val("op_waddr", write_addr, mpc);
            check_val("op_wval", write_value, b0);
            step();
            if (len == 2) begin
                check_val("imm_wflag", write_flag, 1);
                check_val("imm_waddr", write_addr, mpc + 1);
                check_val("imm_wval", write_value, b1);
                check_val("imm_pc", pc, mpc + 1);
                step();
            end
            mpc += len;
            check_val("post_wflag", write_flag, 0);
            check_val("post_wval", write_value, 0);
            check_val("post_pc", pc, mpc);
            if (op == 9) begin
                mhalt = 1;
                check_val("hlt_halted", halted, 1);
                check_val("hlt_ready", in_ready, 0);
            end else begin
                check_val("post_ready", in_ready, 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 4'd0;
        in_x = 2'd0;
        in_y = 2'd0;
        in_use_imm = 1'b0;
        in_imm = 8'd0;
        do_reset();

        issue(0, 0, 0, 1, 8'h05);   // MOV a,#05
        issue(1, 1, 2, 0, 0);       // ADD b,c
        issue(3, 3, 0, 1, 8'h07);   // CMP d,#07
        issue(8, 0, 0, 0, 8'h00);   // JNZ 0x00 -> offset F9
        issue(4, 3, 0, 0, 0);       // PUSH d
        issue(5, 0, 0, 0, 0);       // POP a
        check_val("pc_directed", pc, 9);

        while (mpc < MEMSIZE - 1) issue(4, 0, 0, 0, 0);
        check_val("pc_63", pc, 63);
        issue(0, 0, 0, 1, 8'h01);   // no room for 2 bytes
        issue(4, 0, 0, 0, 0);       // last byte fits
        check_val("pc_full", pc, MEMSIZE);
        issue(5, 1, 0, 0, 0);       // memory full

        do_reset();
        issue(12, 0, 0, 0, 0);
        issue(9, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            scramble_inputs();
            step();
            check_val("halt_ready", in_ready, 0);
            check_val("halt_flag", halted, 1);
            check_val("halt_wflag", write_flag, 0);
            check_val("halt_pc", pc, mpc);
        end
        in_valid = 1'b0;

        // Reset while the immediate of MOV c,#AA is on the write port.
        do_reset();
        in_valid = 1'b1;
        in_op = 4'd0;
        in_x = 2'd2;
        in_y = 2'd0;
        in_use_imm = 1'b1;
        in_imm = 8'hAA;
        step();
        in_valid = 1'b0;
        check_val("abort_op", write_value, 8'h48);
        step();
        rst = 1'b1;
        #1;
        check_val("abort_wflag", write_flag, 0);
        check_val("abort_wval", write_value, 0);
        step();
        rst = 1'b0;
        step();
        check_val("abort_ready", in_ready, 1);
        check_val("abort_pc", pc, 0);
        check_val("abort_after_wflag", write_flag, 0);
        mpc = 0;
        mhalt = 0;

        for (int i = 0; i < 300; i++) begin
            if (mhalt || (mpc >= MEMSIZE - 1 && $urandom_range(0, 3) == 0)) do_reset();
            issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
